cache_data_array_nway: RTL
==========================

# cache_data_array_nway

Parametrised N-way set-associative cache data array with a built-in line-fill sequencer. It holds WAYS×SETS lines of WORDS words each, returns all ways of a set on a registered read for parallel tag compare, accepts single-word store-hit writes, and fills a whole line from memory one word per beat, critical word first. It sits between the cache controller (tag/LRU logic) and the memory interface, and replaces the fixed 4-way/32-block tristate array.

## Interface
Parameters:
- WAYS, 4, associativity (power of 2, ≥1)
- SETS, 32, sets per way (power of 2)
- WORDS, 8, words per line (power of 2, ≥2)
- WIDTH, 16, bits per word
- SW/WW/AW (derived): $clog2(SETS), $clog2(WORDS), max(1,$clog2(WAYS))

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  read request
- rd_set  in  SW  read set index
- rd_word  in  WW  read word offset
- rd_data  out  WAYS*WIDTH  way w at bits [w*WIDTH +: WIDTH]
- rd_valid  out  1  rd_data valid
- wr_en  in  1  store-hit write request
- wr_set, wr_way, wr_word  in  SW/AW/WW  write location
- wr_data  in  WIDTH  write data
- wr_ready  out  1  write accepted when wr_en & wr_ready
- fill_start  in  1  begin line fill (pulse)
- fill_set, fill_way, fill_word  in  SW/AW/WW  target line and first (critical) word
- fill_valid  in  1  fill beat present
- fill_data  in  WIDTH  fill beat data
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse, last beat written

## Operation
- Storage: WAYS×SETS×WORDS flops, cleared to 0 on reset.
- Fill FSM states: IDLE, FILL.
  - IDLE: fill_start latches set/way/word into fill registers, beat counter = 0 → FILL. fill_valid ignored in IDLE.
  - FILL: each cycle with fill_valid writes fill_data to (set, way, ptr); ptr increments modulo WORDS (wraps WORDS-1 → 0); counter increments. Beat with counter = WORDS-1 → fill_done=1 that cycle, → IDLE.
  - fill_start while FILL: ignored. fill_valid gaps: FSM holds.
- wr_ready = ~fill_busy. Writes refused during fill; controller retries.
- Read: any cycle, including during FILL; returns current array contents of all ways (partially filled line returns mix of new and old words).
- Simultaneous fill beat and write cannot occur (wr_ready low). Read and write/fill beat to the same location in one cycle: see Configuration.

## Timing
- Reset values: rd_data=0, rd_valid=0, wr_ready=1, fill_busy=0, fill_done=0, FSM=IDLE, counters=0.
- Read latency 1: rd_en sampled at edge k → rd_data/rd_valid at k+1; rd_valid low the cycle after no rd_en; rd_data holds last value.
- Write: visible to reads issued from the next cycle.
- fill_start at edge k → fill_busy=1 from k+1; first beat accepted at k+1 earliest. fill_busy drops the cycle after fill_done.
- Minimum fill: WORDS+1 cycles from fill_start to IDLE.
- Reset asserted mid-fill: immediate abort, FSM IDLE, array cleared, no fill_done.

## Configuration
- DATA_ARRAY_BYPASS_EN defined: read in same cycle as a write or fill beat to the same set/word returns the new data in the written way (other ways from array).
- Undefined: such a read returns old data; new data visible next read.

## Test plan
- Reset then read set 0 word 0 → rd_data all 0, rd_valid one cycle after rd_en; wr_ready=1.
- Fill set 5 way 2 from word 6, beats 0xA000..0xA007 → words 6,7,0..5 hold A000..A007; fill_done on 8th beat; fill_busy low next cycle.
- Fill with fill_valid gaps and second fill_start mid-fill → second ignored, wr_ready=0 throughout, exactly 8 words written.
- Write 0x1234 to set 3 way 1 word 4, read next cycle → way-1 slice 0x1234, other ways unchanged.
- Same-cycle write 0xBEEF and read of set 3 word 4 (old 0x1234) → 0xBEEF with DATA_ARRAY_BYPASS_EN, 0x1234 without.
- Assert rst after 3 fill beats → fill_busy=0, no fill_done, all words read 0.

Source files
------------

// File: rtl/cache_data_array_nway_if.sv
// Bundles the read, store-hit write and line-fill signals of cache_data_array_nway.
// The master modport is the cache controller side and the slave modport is the data array side.
interface cache_data_array_nway_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 32,
  parameter int WORDS = 8,
  parameter int WIDTH = 16
);
  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WORDS);
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                  rd_en;
  logic [SW-1:0]         rd_set;
  logic [WW-1:0]         rd_word;
  logic [WAYS*WIDTH-1:0] rd_data;
  logic                  rd_valid;

  logic                  wr_en;
  logic [SW-1:0]         wr_set;
  logic [AW-1:0]         wr_way;
  logic [WW-1:0]         wr_word;
  logic [WIDTH-1:0]      wr_data;
  logic                  wr_ready;

  logic                  fill_start;
  logic [SW-1:0]         fill_set;
  logic [AW-1:0]         fill_way;
  logic [WW-1:0]         fill_word;
  logic                  fill_valid;
  logic [WIDTH-1:0]      fill_data;
  logic                  fill_busy;
  logic                  fill_done;

  modport master (
    output rd_en, rd_set, rd_word,
    output wr_en, wr_set, wr_way, wr_word, wr_data,
    output fill_start, fill_set, fill_way, fill_word, fill_valid, fill_data,
    input  rd_data, rd_valid, wr_ready, fill_busy, fill_done
  );

  modport slave (
    input  rd_en, rd_set, rd_word,
    input  wr_en, wr_set, wr_way, wr_word, wr_data,
    input  fill_start, fill_set, fill_way, fill_word, fill_valid, fill_data,
    output rd_data, rd_valid, wr_ready, fill_busy, fill_done
  );
endinterface

// File: rtl/cache_data_array_nway.sv
// N-way set-associative cache data array with a critical-word-first line-fill sequencer.
// Define DATA_ARRAY_BYPASS_EN to forward same-cycle write/fill data to a colliding read.
module cache_data_array_nway #(
  parameter int WAYS  = 4,
  parameter int SETS  = 32,
  parameter int WORDS = 8,
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  cache_data_array_nway_if.slave bus
);
  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WORDS);
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [WIDTH-1:0]      mem_q [WAYS][SETS][WORDS];
  logic [0:0]            state_q, state_d;
  logic [SW-1:0]         fill_set_q, fill_set_d;
  logic [AW-1:0]         fill_way_q, fill_way_d;
  logic [WW-1:0]         fill_ptr_q, fill_ptr_d;
  logic [WW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [WAYS*WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q;

  logic fill_busy, wr_fire, beat_fire, last_beat;

  assign fill_busy = (state_q == S_FILL);
  assign wr_fire   = bus.wr_en & ~fill_busy;
  assign beat_fire = fill_busy & bus.fill_valid;
  assign last_beat = beat_fire & (beat_cnt_q == WW'(WORDS - 1));

  assign bus.fill_busy = fill_busy;
  assign bus.wr_ready  = ~fill_busy;
  assign bus.fill_done = last_beat;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

  // Fill sequencer: the pointer wraps naturally because WORDS is a power of two.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    fill_set_d = fill_set_q;
    fill_way_d = fill_way_q;
    fill_ptr_d = fill_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.fill_start) begin
          state_d    = S_FILL;
          fill_set_d = bus.fill_set;
          fill_way_d = bus.fill_way;
          fill_ptr_d = bus.fill_word;
          beat_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (bus.fill_valid) begin
          fill_ptr_d = fill_ptr_q + WW'(1);
          beat_cnt_d = beat_cnt_q + WW'(1);
          if (last_beat) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.rd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_data_d[w*WIDTH +: WIDTH] = mem_q[w][bus.rd_set][bus.rd_word];
      end
`ifdef DATA_ARRAY_BYPASS_EN
      if (wr_fire && bus.wr_set == bus.rd_set && bus.wr_word == bus.rd_word)
        rd_data_d[int'(bus.wr_way)*WIDTH +: WIDTH] = bus.wr_data;
      if (beat_fire && fill_set_q == bus.rd_set && fill_ptr_q == bus.rd_word)
        rd_data_d[int'(fill_way_q)*WIDTH +: WIDTH] = bus.fill_data;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fill_set_q <= '0;
      fill_way_q <= '0;
      fill_ptr_q <= '0;
      beat_cnt_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_set_q <= fill_set_d;
      fill_way_q <= fill_way_d;
      fill_ptr_q <= fill_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= bus.rd_en;
    end
  end

  // NOTE: the array is built from flops rather than a RAM macro, so it can and must be cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          for (int i = 0; i < WORDS; i++)
            mem_q[w][s][i] <= '0;
    end else begin
      if (wr_fire)   mem_q[bus.wr_way][bus.wr_set][bus.wr_word] <= bus.wr_data;
      if (beat_fire) mem_q[fill_way_q][fill_set_q][fill_ptr_q]  <= bus.fill_data;
    end
  end
endmodule
